// File: rtl/msg_word_packer.sv
// Byte-stream to 32-bit word packer with a small word FIFO and paced single-cycle word strobes.
// Optional error counter output enabled by defining PACKER_ERR_CNT_EN.
module msg_word_packer #(
    parameter int unsigned MST_DWIDTH = 32,
    parameter int unsigned SYS_DWIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                  clk_mst,
    input  logic                  rst_n,
    input  logic [SYS_DWIDTH-1:0] byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    input  logic                  sop_i,
    input  logic                  eop_i,
    output logic [MST_DWIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic [1:0]            select_o,
    output logic                  busy_o,
`ifdef PACKER_ERR_CNT_EN
    output logic [7:0]            err_cnt_o,
`endif
    output logic                  err_o
);

    localparam int unsigned NumLanes = MST_DWIDTH / SYS_DWIDTH;
    localparam int unsigned LaneW    = $clog2(NumLanes);
    localparam int unsigned AddrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrW     = AddrW + 1;
    localparam int unsigned GapW     = $clog2(GAP_CYCLES + 1);
    localparam int unsigned EntryW   = MST_DWIDTH + 2;

    typedef enum logic [1:0] {InIdle, InCollect, InDiscard} in_state_e;
    typedef enum logic {OutIdle, OutGap} out_state_e;

    in_state_e             in_state_q, in_state_d;
    logic [1:0]            sel_q, sel_d;
    logic [MST_DWIDTH-1:0] word_q, word_d;
    logic [LaneW-1:0]      idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  ready_q;

    out_state_e            out_state_q, out_state_d;
    logic [GapW-1:0]       gap_q, gap_d;
    logic [MST_DWIDTH-1:0] data_q, data_d;
    logic [1:0]            sel_out_q, sel_out_d;
    logic                  valid_q, valid_d;

    logic [EntryW-1:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  empty, full_d;

    logic                  accept, take_hdr, push, pop;
    logic [MST_DWIDTH-1:0] push_word;
    logic [EntryW-1:0]     head;

    assign accept = byte_valid_i && ready_q;

    // Input side: header decode and LSB-first lane packing.
    always_comb begin
        in_state_d = in_state_q;
        sel_d      = sel_q;
        word_d     = word_q;
        idx_d      = idx_q;
        err_d      = 1'b0;
        push       = 1'b0;
        take_hdr   = 1'b0;
        push_word  = word_q | (MST_DWIDTH'(byte_i) << (SYS_DWIDTH * 32'(idx_q)));
        unique case (in_state_q)
            InIdle: begin
                if (accept) begin
                    if (sop_i) take_hdr = 1'b1;
                    else       err_d    = 1'b1;
                end
            end
            InCollect: begin
                if (accept) begin
                    if (sop_i) begin
                        err_d    = 1'b1;
                        take_hdr = 1'b1;
                    end else begin
                        word_d = push_word;
                        idx_d  = idx_q + LaneW'(1);
                        if (idx_q == LaneW'(NumLanes - 1) || eop_i) begin
                            push   = 1'b1;
                            idx_d  = '0;
                            word_d = '0;
                        end
                        if (eop_i) in_state_d = InIdle;
                    end
                end
            end
            InDiscard: begin
                if (accept && eop_i) in_state_d = InIdle;
            end
            default: in_state_d = InIdle;
        endcase

        if (take_hdr) begin
            word_d = '0;
            idx_d  = '0;
            if (byte_i[1:0] == 2'd3) begin
                err_d      = 1'b1;
                in_state_d = eop_i ? InIdle : InDiscard;
            end else if (eop_i) begin
                in_state_d = InIdle;
            end else begin
                sel_d      = byte_i[1:0];
                in_state_d = InCollect;
            end
        end
    end

    // FIFO pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign head     = mem_q[rd_ptr_q[AddrW-1:0]];
    assign wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    assign full_d   = (wr_ptr_d[PtrW-1] != rd_ptr_d[PtrW-1]) &&
                      (wr_ptr_d[AddrW-1:0] == rd_ptr_d[AddrW-1:0]);

    always_ff @(posedge clk_mst) begin
        if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= {sel_q, push_word};
    end

    // Output side: one pop per strobe, then hold off for GAP_CYCLES cycles.
    always_comb begin
        out_state_d = out_state_q;
        gap_d       = gap_q;
        data_d      = data_q;
        sel_out_d   = sel_out_q;
        valid_d     = 1'b0;
        pop         = 1'b0;
        unique case (out_state_q)
            OutIdle: begin
                if (!empty) begin
                    pop         = 1'b1;
                    valid_d     = 1'b1;
                    data_d      = head[MST_DWIDTH-1:0];
                    sel_out_d   = head[EntryW-1 -: 2];
                    gap_d       = GapW'(GAP_CYCLES);
                    out_state_d = OutGap;
                end
            end
            OutGap: begin
                if (gap_q <= GapW'(1)) begin
                    gap_d       = '0;
                    out_state_d = OutIdle;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            default: out_state_d = OutIdle;
        endcase
    end

    always_ff @(posedge clk_mst) begin
        if (!rst_n) begin
            in_state_q  <= InIdle;
            sel_q       <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_state_q <= OutIdle;
            gap_q       <= '0;
            data_q      <= '0;
            sel_out_q   <= '0;
            valid_q     <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            sel_q       <= sel_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            ready_q     <= !full_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_state_q <= out_state_d;
            gap_q       <= gap_d;
            data_q      <= data_d;
            sel_out_q   <= sel_out_d;
            valid_q     <= valid_d;
        end
    end

`ifdef PACKER_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk_mst) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_d && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

    assign byte_ready_o = ready_q;
    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign select_o     = sel_out_q;
    assign err_o        = err_q;
    assign busy_o       = !empty || (in_state_q == InCollect) || (out_state_q == OutGap);

endmodule

// File: tb/tb_msg_word_packer.sv
// Directed self-checking bench for msg_word_packer: packing, pacing, back-pressure, errors, reset.
module tb_msg_word_packer;

    logic        clk_mst = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        sop_i;
    logic        eop_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic [1:0]  select_o;
    logic        busy_o;
    logic        err_o;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;

    logic [31:0] vq_data[$];
    logic [1:0]  vq_sel[$];
    int unsigned vq_cyc[$];
    int unsigned err_seen = 0;

    msg_word_packer dut (
        .clk_mst      (clk_mst),
        .rst_n        (rst_n),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .sop_i        (sop_i),
        .eop_i        (eop_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .select_o     (select_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk_mst = ~clk_mst;

    // Records every strobe with the edge number after which it was seen.
    always @(posedge clk_mst) begin
        cyc++;
        #1;
        if (valid_o === 1'b1) begin
            vq_data.push_back(data_o);
            vq_sel.push_back(select_o);
            vq_cyc.push_back(cyc);
        end
        if (err_o === 1'b1) err_seen++;
    end

    task automatic tick();
        @(posedge clk_mst);
        #1;
    endtask

    task automatic clear_log();
        vq_data.delete();
        vq_sel.delete();
        vq_cyc.delete();
        err_seen = 0;
    endtask

    task automatic idle_inputs();
        byte_valid_i = 1'b0;
        sop_i        = 1'b0;
        eop_i        = 1'b0;
        byte_i       = 8'h00;
    endtask

    // Holds byte_valid_i high until the byte is taken; returns the accepting edge number.
    task automatic send(input logic [7:0] b, input logic sop, input logic eop,
                        output int unsigned edge_n);
        byte_i       = b;
        sop_i        = sop;
        eop_i        = eop;
        byte_valid_i = 1'b1;
        edge_n       = 0;
        for (int w = 0; w < 200; w++) begin
            if (byte_ready_o === 1'b1) begin
                tick();
                edge_n = cyc;
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %h not accepted within 200 cycles", b);
    endtask

    task automatic wait_pulses(input int n, input int budget, input string name);
        for (int w = 0; w < budget && vq_data.size() < n; w++) tick();
        checks++;
        if (vq_data.size() < n) begin
            errors++;
            $display("FAIL %s_pulse_count: got %0d required %0d", name, vq_data.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int w = 0; w < 100 && busy_o !== 1'b0; w++) tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy_o=%b required 0", name, busy_o);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks += 6;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL %s_valid: got %b required 0", name, valid_o);
        end
        if (data_o !== 32'h0) begin
            errors++; $display("FAIL %s_data: got %h required 0", name, data_o);
        end
        if (select_o !== 2'd0) begin
            errors++; $display("FAIL %s_select: got %0d required 0", name, select_o);
        end
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL %s_err: got %b required 0", name, err_o);
        end
        if (byte_ready_o !== 1'b0) begin
            errors++; $display("FAIL %s_ready: got %b required 0", name, byte_ready_o);
        end
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL %s_busy: got %b required 0", name, busy_o);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();
        checks++;
        if (byte_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after: got %b required 1", byte_ready_o);
        end
    endtask

    task automatic test_single_word();
        int unsigned e;
        logic [7:0] pay [4];
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_log();
        send(8'h01, 1'b1, 1'b0, e);
        for (int i = 0; i < 4; i++) send(pay[i], 1'b0, i == 3, e);
        idle_inputs();
        wait_pulses(1, 40, "single");
        checks += 4;
        if (vq_data[0] !== 32'h44332211) begin
            errors++; $display("FAIL single_data: got %h required 44332211", vq_data[0]);
        end
        if (vq_sel[0] !== 2'd1) begin
            errors++; $display("FAIL single_select: got %0d required 1", vq_sel[0]);
        end
        if (vq_cyc[0] !== e + 1) begin
            errors++; $display("FAIL single_latency: pulse edge %0d required %0d", vq_cyc[0], e + 1);
        end
        if (err_seen != 0) begin
            errors++; $display("FAIL single_err: got %0d pulses required 0", err_seen);
        end
        wait_idle("single");
        checks++;
        if (data_o !== 32'h44332211) begin
            errors++; $display("FAIL single_data_hold: got %h required 44332211", data_o);
        end
    endtask

    task automatic test_partial_word();
        int unsigned e;
        logic [7:0] pay [6];
        pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        clear_log();
        send(8'h02, 1'b1, 1'b0, e);
        for (int i = 0; i < 6; i++) send(pay[i], 1'b0, i == 5, e);
        idle_inputs();
        wait_pulses(2, 60, "partial");
        checks += 5;
        if (vq_data[0] !== 32'hDDCCBBAA) begin
            errors++; $display("FAIL partial_word0: got %h required ddccbbaa", vq_data[0]);
        end
        if (vq_data[1] !== 32'h0000FFEE) begin
            errors++; $display("FAIL partial_word1: got %h required 0000ffee", vq_data[1]);
        end
        if (vq_sel[0] !== 2'd2 || vq_sel[1] !== 2'd2) begin
            errors++; $display("FAIL partial_select: got %0d,%0d required 2,2", vq_sel[0], vq_sel[1]);
        end
        if (vq_cyc[1] - vq_cyc[0] != 17) begin
            errors++; $display("FAIL partial_spacing: got %0d required 17", vq_cyc[1] - vq_cyc[0]);
        end
        if (err_seen != 0) begin
            errors++; $display("FAIL partial_err: got %0d pulses required 0", err_seen);
        end
        wait_idle("partial");
    endtask

    task automatic test_back_to_back();
        int unsigned e;
        logic [31:0] exp_w;
        clear_log();
        send(8'h01, 1'b1, 1'b0, e);
        for (int i = 0; i < 20; i++) send(8'h10 + 8'(i), 1'b0, i == 19, e);
        // Fifth word lands while words 2..5 are all still queued.
        checks++;
        if (byte_ready_o !== 1'b0) begin
            errors++; $display("FAIL b2b_ready_full: got %b required 0", byte_ready_o);
        end
        idle_inputs();
        wait_pulses(5, 150, "b2b");
        for (int j = 0; j < 5; j++) begin
            exp_w = {8'h13 + 8'(4 * j), 8'h12 + 8'(4 * j), 8'h11 + 8'(4 * j), 8'h10 + 8'(4 * j)};
            checks += 2;
            if (vq_data[j] !== exp_w) begin
                errors++; $display("FAIL b2b_word%0d: got %h required %h", j, vq_data[j], exp_w);
            end
            if (vq_sel[j] !== 2'd1) begin
                errors++; $display("FAIL b2b_select%0d: got %0d required 1", j, vq_sel[j]);
            end
            if (j > 0) begin
                checks++;
                if (vq_cyc[j] - vq_cyc[j-1] != 17) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: got %0d required 17", j, vq_cyc[j] - vq_cyc[j-1]);
                end
            end
        end
        wait_idle("b2b");
        checks++;
        if (byte_ready_o !== 1'b1 || vq_data.size() != 5) begin
            errors++;
            $display("FAIL b2b_final: ready=%b pulses=%0d required 1 and 5", byte_ready_o, vq_data.size());
        end
    endtask

    task automatic test_bad_select();
        int unsigned e;
        clear_log();
        send(8'h03, 1'b1, 1'b0, e);
        send(8'h01, 1'b0, 1'b0, e);
        send(8'h02, 1'b0, 1'b0, e);
        send(8'h03, 1'b0, 1'b1, e);
        idle_inputs();
        for (int i = 0; i < 30; i++) tick();
        checks += 3;
        if (err_seen != 1) begin
            errors++; $display("FAIL badsel_err: got %0d pulses required 1", err_seen);
        end
        if (vq_data.size() != 0) begin
            errors++; $display("FAIL badsel_valid: got %0d pulses required 0", vq_data.size());
        end
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL badsel_busy: got %b required 0", busy_o);
        end
    endtask

    task automatic test_sop_abort();
        int unsigned e;
        clear_log();
        send(8'h01, 1'b1, 1'b0, e);
        send(8'h5A, 1'b0, 1'b0, e);
        send(8'h6B, 1'b0, 1'b0, e);
        send(8'h02, 1'b1, 1'b0, e);
        send(8'h01, 1'b0, 1'b0, e);
        send(8'h02, 1'b0, 1'b0, e);
        send(8'h03, 1'b0, 1'b1, e);
        idle_inputs();
        wait_pulses(1, 40, "abort");
        for (int i = 0; i < 25; i++) tick();
        checks += 4;
        if (err_seen != 1) begin
            errors++; $display("FAIL abort_err: got %0d pulses required 1", err_seen);
        end
        if (vq_data.size() != 1) begin
            errors++; $display("FAIL abort_count: got %0d pulses required 1", vq_data.size());
        end
        if (vq_data[0] !== 32'h00030201) begin
            errors++; $display("FAIL abort_data: got %h required 00030201", vq_data[0]);
        end
        if (vq_sel[0] !== 2'd2) begin
            errors++; $display("FAIL abort_select: got %0d required 2", vq_sel[0]);
        end
    endtask

    task automatic test_reset_mid_gap();
        int unsigned e;
        clear_log();
        send(8'h01, 1'b1, 1'b0, e);
        for (int i = 0; i < 12; i++) send(8'hA0 + 8'(i), 1'b0, i == 11, e);
        idle_inputs();
        tick();
        tick();
        checks++;
        if (vq_data.size() != 1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL midgap_pre: pulses=%0d busy=%b required 1 and 1", vq_data.size(), busy_o);
        end
        rst_n = 1'b0;
        tick();
        check_outputs_zero("midgap_reset");
        rst_n = 1'b1;
        clear_log();
        tick();
        checks++;
        if (byte_ready_o !== 1'b1) begin
            errors++; $display("FAIL midgap_ready_after: got %b required 1", byte_ready_o);
        end
        for (int i = 0; i < 60; i++) tick();
        checks += 2;
        if (vq_data.size() != 0) begin
            errors++; $display("FAIL midgap_flushed: got %0d pulses required 0", vq_data.size());
        end
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL midgap_busy: got %b required 0", busy_o);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_word();
        test_partial_word();
        test_back_to_back();
        test_bad_select();
        test_sop_abort();
        test_reset_mid_gap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
